// File: rtl/pool_scheduler.sv
// Sequencer for the 2-wide max-pooling datapath (PISO, comparators, row FIFO).
// Optional STALL_CNT output enabled by POOL_SCHED_STALL_CNT_EN.
module pool_scheduler #(
  parameter int NUM_PE         = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int ROW_FIFO_DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [COUNTER_WIDTH-1:0] CFG_ROW_WORDS,
  input  logic [COUNTER_WIDTH-1:0] CFG_ROWS,
  input  logic [1:0]               CFG_POOL_Y,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic                     PISO_LOAD,
  output logic                     PISO_SHIFT,
  output logic                     SEL_FIRST,
  output logic                     ROW_PUSH,
  output logic                     ROW_POP,
  output logic                     OUT_EMIT,
  output logic                     BUSY,
  output logic                     DONE,
`ifdef POOL_SCHED_STALL_CNT_EN
  output logic [15:0]              STALL_CNT,
`endif
  output logic                     CFG_ERR
);

  localparam int HALF = NUM_PE / 2;
  localparam int PCW  = $clog2(NUM_PE);
  localparam int FW   = $clog2(ROW_FIFO_DEPTH + 1);
  localparam int CW   = COUNTER_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SHIFT, S_FLUSH, S_FIN
  } state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_row_words, r_rows, r_word, r_row;
  logic [1:0]     r_pool, r_wrow, w_pool_in, w_wrow_nxt;
  logic [PCW-1:0] r_pair;
  logic [FW-1:0]  r_flush;
  logic           r_sel, r_push, r_pop, r_emit, r_cfg_err;
  logic [31:0]    w_req;
  logic           w_too_big, w_empty, w_start_ok;
  logic           w_step, w_last_pair, w_word_end;
  logic           w_row_end, w_frame_end, w_flush_step;
  logic           w_sel, w_push, w_pop, w_emit;

  assign w_req      = 32'(CFG_ROW_WORDS) * 32'(HALF);
  assign w_too_big  = w_req > 32'(ROW_FIFO_DEPTH);
  assign w_empty    = (CFG_ROW_WORDS == '0) || (CFG_ROWS == '0);
  assign w_start_ok = (r_state == S_IDLE) && START && !w_too_big;
  assign w_pool_in  = (CFG_POOL_Y == 2'd0) ? 2'd1 : CFG_POOL_Y;

  assign w_step      = PISO_LOAD | PISO_SHIFT;
  assign w_last_pair = (r_state == S_WAIT) ? (HALF == 1)
                     : (r_pair == PCW'(HALF - 1));
  assign w_word_end  = w_step && w_last_pair;
  assign w_row_end   = w_word_end && (r_word == r_row_words - CW'(1));
  assign w_frame_end = w_row_end && (r_row == r_rows - CW'(1));
  assign w_wrow_nxt  = (r_wrow == r_pool - 2'd1) ? 2'd0 : r_wrow + 2'd1;

  always_comb begin
    w_next       = r_state;
    IN_READY     = 1'b0;
    PISO_LOAD    = 1'b0;
    PISO_SHIFT   = 1'b0;
    DONE         = 1'b0;
    w_flush_step = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START && !w_too_big)
          w_next = w_empty ? S_FIN : S_WAIT;
      end
      S_WAIT: begin
        IN_READY  = 1'b1;
        PISO_LOAD = IN_VALID;
        if (IN_VALID) begin
          if (w_frame_end)   w_next = S_FLUSH;
          else if (HALF > 1) w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        PISO_SHIFT = 1'b1;
        if (w_last_pair)
          w_next = w_frame_end ? S_FLUSH : S_WAIT;
      end
      S_FLUSH: begin
        // a zero count still costs one cycle so the last strobe drains
        if (r_flush != '0) w_flush_step = 1'b1;
        else               w_next = S_FIN;
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel  = 1'b0;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_emit = 1'b0;
    if (w_step) begin
      if (r_pool == 2'd1) begin
        w_sel  = 1'b1;
        w_emit = 1'b1;
      end else if (r_wrow == 2'd0) begin
        w_sel  = 1'b1;
        w_push = 1'b1;
      end else if (r_wrow == r_pool - 2'd1) begin
        w_pop  = 1'b1;
        w_emit = 1'b1;
      end else begin
        w_pop  = 1'b1;
        w_push = 1'b1;
      end
    end else if (w_flush_step) begin
      w_pop = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_row_words <= '0;
      r_rows      <= '0;
      r_pool      <= 2'd1;
      r_pair      <= '0;
      r_word      <= '0;
      r_row       <= '0;
      r_wrow      <= '0;
      r_flush     <= '0;
      r_sel       <= 1'b0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_emit      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sel     <= w_sel;
      r_push    <= w_push;
      r_pop     <= w_pop;
      r_emit    <= w_emit;
      r_cfg_err <= (r_state == S_IDLE) && START && w_too_big;
      if (w_start_ok) begin
        r_row_words <= CFG_ROW_WORDS;
        r_rows      <= CFG_ROWS;
        r_pool      <= w_pool_in;
        r_word      <= '0;
        r_row       <= '0;
        r_wrow      <= '0;
      end
      if (PISO_LOAD)       r_pair <= PCW'(1);
      else if (PISO_SHIFT) r_pair <= r_pair + PCW'(1);
      if (w_word_end) begin
        r_word <= w_row_end ? '0 : r_word + CW'(1);
        if (w_row_end) begin
          r_row  <= r_row + CW'(1);
          r_wrow <= w_wrow_nxt;
        end
      end
      if (w_frame_end)
        r_flush <= (w_wrow_nxt != 2'd0)
                 ? FW'(32'(r_row_words) * 32'(HALF)) : '0;
      else if (w_flush_step)
        r_flush <= r_flush - FW'(1);
    end
  end

`ifdef POOL_SCHED_STALL_CNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      r_stall <= '0;
    else if (w_start_ok)
      r_stall <= '0;
    else if (r_state == S_WAIT && !IN_VALID && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end
  assign STALL_CNT = r_stall;
`endif

  assign SEL_FIRST = r_sel;
  assign ROW_PUSH  = r_push;
  assign ROW_POP   = r_pop;
  assign OUT_EMIT  = r_emit;
  assign BUSY      = (r_state != S_IDLE);
  assign CFG_ERR   = r_cfg_err;

endmodule

// File: tb/tb_pool_scheduler.sv
// Scoreboard bench for pool_scheduler: per-cycle output vectors
// derived from a frame timeline model, compared on the falling edge.
module tb_pool_scheduler;

  logic       CLK = 1'b0;
  logic       RESET, START, IN_VALID;
  logic [7:0] CFG_ROW_WORDS, CFG_ROWS;
  logic [1:0] CFG_POOL_Y;
  logic       IN_READY, PISO_LOAD, PISO_SHIFT, SEL_FIRST;
  logic       ROW_PUSH, ROW_POP, OUT_EMIT, BUSY, DONE, CFG_ERR;
`ifdef POOL_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pool_scheduler #(
    .NUM_PE(4), .COUNTER_WIDTH(8), .ROW_FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .CFG_ROW_WORDS(CFG_ROW_WORDS), .CFG_ROWS(CFG_ROWS),
    .CFG_POOL_Y(CFG_POOL_Y), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .PISO_LOAD(PISO_LOAD),
    .PISO_SHIFT(PISO_SHIFT), .SEL_FIRST(SEL_FIRST),
    .ROW_PUSH(ROW_PUSH), .ROW_POP(ROW_POP), .OUT_EMIT(OUT_EMIT),
    .BUSY(BUSY), .DONE(DONE),
`ifdef POOL_SCHED_STALL_CNT_EN
    .STALL_CNT(stall_cnt),
`endif
    .CFG_ERR(CFG_ERR)
  );

  always #5 CLK = ~CLK;

  // bit order: 9 rdy,8 load,7 shift,6 sel,5 push,4 pop,3 emit,2 busy,1 done,0 err
  logic [9:0] dut_vec;
  assign dut_vec = {IN_READY, PISO_LOAD, PISO_SHIFT, SEL_FIRST,
                    ROW_PUSH, ROW_POP, OUT_EMIT, BUSY, DONE, CFG_ERR};

  int n_vec = 0;
  int n_bad = 0;
  int scen  = 0;
  int cur_c = 0;
  int exp_stall;
  logic [9:0] exp_v [0:63];
  logic [9:0] sb [$];

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      logic [9:0] e;
      e = sb.pop_front();
      check($sformatf("s%0d c%0d", scen, cur_c), 16'(dut_vec), 16'(e));
    end
  end

  // Timeline model: each accepted word occupies 2 pair steps,
  // strobes land one cycle after their step.
  task automatic build(input int words, input int rows, input int py,
                       input int lo, input int hi, output int len);
    int t, k, npair, rw, done, row, r, pyy, last;
    pyy = (py == 0) ? 1 : py;
    for (int i = 0; i < 64; i++) exp_v[i] = '0;
    exp_stall = 0;
    if (words * 2 > 16) begin
      exp_v[1][0] = 1'b1;
      len = 4;
      return;
    end
    if (words == 0 || rows == 0) begin
      exp_v[1][2] = 1'b1;
      exp_v[1][1] = 1'b1;
      len = 3;
      return;
    end
    rw = words * 2;
    npair = rw * rows;
    t = 1; k = 0; last = 0;
    while (k < npair) begin
      exp_v[t][9] = 1'b1;
      if (t >= lo && t <= hi) begin
        exp_stall++;
        t++;
      end else begin
        for (int j = 0; j < 2; j++) begin
          exp_v[t+j][(j == 0) ? 8 : 7] = 1'b1;
          row = k / rw;
          r = row % pyy;
          if (pyy == 1) begin
            exp_v[t+j+1][6] = 1'b1;
            exp_v[t+j+1][3] = 1'b1;
          end else if (r == 0) begin
            exp_v[t+j+1][6] = 1'b1;
            exp_v[t+j+1][5] = 1'b1;
          end else if (r == pyy - 1) begin
            exp_v[t+j+1][4] = 1'b1;
            exp_v[t+j+1][3] = 1'b1;
          end else begin
            exp_v[t+j+1][4] = 1'b1;
            exp_v[t+j+1][5] = 1'b1;
          end
          last = t + j;
          k++;
        end
        t += 2;
      end
    end
    if (rows % pyy != 0) begin
      for (int f = 0; f < rw; f++) exp_v[last+2+f][4] = 1'b1;
      done = last + 2 + rw;
    end else begin
      done = last + 2;
    end
    exp_v[done][1] = 1'b1;
    for (int i = 1; i <= done; i++) exp_v[i][2] = 1'b1;
    len = done + 3;
  endtask

  task automatic run(input int words, input int rows, input int py,
                     input int lo, input int hi, input int st2);
    int len;
    scen++;
    build(words, rows, py, lo, hi, len);
    for (int c = 0; c < len; c++) begin
      cur_c         = c;
      START         = (c == 0) || (c == st2);
      CFG_ROW_WORDS = 8'(words);
      CFG_ROWS      = 8'(rows);
      CFG_POOL_Y    = 2'(py);
      IN_VALID      = (c >= 1) && !(c >= lo && c <= hi);
      sb.push_back(exp_v[c]);
      @(posedge CLK);
      #1;
    end
    START    = 1'b0;
    IN_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0;
    CFG_ROW_WORDS = '0; CFG_ROWS = '0; CFG_POOL_Y = '0;
    #3 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst", 16'(dut_vec), 16'h0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    run(2, 2, 2, 0, -1, -1);
    run(2, 2, 1, 0, -1, -1);
    run(1, 3, 2, 0, -1, -1);
    run(9, 2, 2, 0, -1, -1);
    run(2, 2, 2, 3, 4, -1);
`ifdef POOL_SCHED_STALL_CNT_EN
    check("stall2", stall_cnt, 16'(exp_stall));
`endif
    run(2, 2, 2, 0, -1, 3);
`ifdef POOL_SCHED_STALL_CNT_EN
    check("stall0", stall_cnt, 16'(exp_stall));
`endif
    run(1, 3, 3, 0, -1, -1);
    run(2, 2, 0, 0, -1, -1);
    run(0, 2, 2, 0, -1, -1);

    START = 1'b1; CFG_ROW_WORDS = 8'd2; CFG_ROWS = 8'd2;
    CFG_POOL_Y = 2'd2; IN_VALID = 1'b0;
    @(posedge CLK);
    #1 START = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    check("inshift", 16'(PISO_SHIFT), 16'h1);
    RESET = 1'b0;
    #1;
    check("rstmid", 16'(dut_vec), 16'h0);
    @(posedge CLK);
    #1 RESET = 1'b1; IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    run(2, 2, 2, 0, -1, -1);

    repeat (2) @(posedge CLK);
    if (sb.size() != 0) check("sbempty", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_scheduler.md
Name: pool_scheduler

Overview:
- Sequencing controller for the 2-wide max-pooling datapath: PISO unpack, comparator pair, row FIFO and mux.
- Accepts NUM_PE-lane input words over a valid/ready handshake and issues the PISO load/shift strobes.
- Tracks column, window-row and frame-row position, then drives row-FIFO push/pop, first-row mux select and output-emit strobes.
- Sits between the PE array output and the pooling datapath. Config is latched per frame from the layer controller.

Parameters:
- NUM_PE, 4, lanes per input word; must be even and >= 2; NUM_PE/2 comparator pairs per word.
- COUNTER_WIDTH, 8, width of the row-word and row config/counters.
- ROW_FIFO_DEPTH, 16, row FIFO entries; bounds the pairs per row.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle frame start pulse; samples CFG_*
- CFG_ROW_WORDS  in  COUNTER_WIDTH  input words per feature-map row
- CFG_ROWS  in  COUNTER_WIDTH  rows per frame
- CFG_POOL_Y  in  2  pool height 1..3; 0 treated as 1
- IN_VALID  in  1  PE-array word valid
- IN_READY  out  1  scheduler can accept a word this cycle
- PISO_LOAD  out  1  load PISO with the handshaken word
- PISO_SHIFT  out  1  shift PISO by one pair
- SEL_FIRST  out  1  mux selects the comparator result directly (first window row)
- ROW_PUSH  out  1  push the mux result into the row FIFO
- ROW_POP  out  1  pop the row FIFO
- OUT_EMIT  out  1  pooled value valid toward the output SIPO
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse at frame completion
- CFG_ERR  out  1  one-cycle pulse when START is rejected

Behaviour:
- Reset (RESET low, async): state IDLE; all counters 0; every output 0.
- FSM states: IDLE, WAIT, SHIFT, FLUSH, FIN.
- IDLE:
  - START latches config.
  - CFG_ROW_WORDS*NUM_PE/2 > ROW_FIFO_DEPTH -> CFG_ERR pulse next cycle; stay IDLE.
  - CFG_ROW_WORDS==0 or CFG_ROWS==0 -> FIN.
  - Otherwise -> WAIT.
- START while BUSY is ignored.
- WAIT:
  - IN_READY=1.
  - IN_VALID&&IN_READY -> PISO_LOAD=1 in the same cycle; pair counter = 1.
  - Next state: SHIFT if NUM_PE>2, else stays WAIT.
- SHIFT:
  - IN_READY=0; PISO_SHIFT=1 each cycle.
  - Pair counter increments; after the NUM_PE/2-1 shifts -> WAIT.
- Each word costs exactly NUM_PE/2 cycles with IN_VALID held high.
- Pair step: every PISO_LOAD or PISO_SHIFT cycle. Datapath strobes are registered and assert exactly 1 cycle after each pair step (comparator latency), based on window row r:
  - POOL_Y==1: SEL_FIRST=1, OUT_EMIT=1; no push or pop.
  - r==0: SEL_FIRST=1, ROW_PUSH=1.
  - 0<r<POOL_Y-1: SEL_FIRST=0, ROW_POP=1, ROW_PUSH=1.
  - r==POOL_Y-1: SEL_FIRST=0, ROW_POP=1, OUT_EMIT=1.
- Counters:
  - Word counter wraps at CFG_ROW_WORDS and increments the row and r counters.
  - r wraps at POOL_Y.
  - After row CFG_ROWS-1 completes -> FIN if r wrapped to 0, else FLUSH.
- FLUSH (partial last window):
  - Entry is one cycle after the last pair step.
  - ROW_POP=1 for CFG_ROW_WORDS*NUM_PE/2 cycles; OUT_EMIT=0; then FIN.
- FIN:
  - Entered one cycle after the last strobe (flush pop or emit).
  - DONE=1 for one cycle; -> IDLE.
- BUSY=1 in all states except IDLE.
- Reset mid-frame: immediate return to IDLE; the row FIFO is reset by the same reset net.

Optional Feature:
- Macro POOL_SCHED_STALL_CNT_EN.
- Defined: adds output STALL_CNT[15:0]. It counts cycles in WAIT with IN_VALID=0, clears on accepted START and saturates at 16'hFFFF.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- NUM_PE=4, START with ROW_WORDS=2, ROWS=2, POOL_Y=2, IN_VALID held 1:
  - Handshakes at cycles 1,3,5,7.
  - ROW_PUSH/SEL_FIRST at cycles 2,3,4,5.
  - ROW_POP/OUT_EMIT at cycles 6,7,8,9.
  - DONE at cycle 10; BUSY low at cycle 11.
- Same config, POOL_Y=1: OUT_EMIT at cycles 2..9; ROW_PUSH and ROW_POP never assert; DONE at cycle 10.
- ROWS=3, POOL_Y=2, ROW_WORDS=1:
  - Row 2 pushes 2 pairs, then FLUSH pops 2 with OUT_EMIT=0.
  - DONE 1 cycle after the last pop.
- ROW_WORDS=9 with ROW_FIFO_DEPTH=16 (18 pairs > 16): CFG_ERR pulse; BUSY stays 0; IN_READY stays 0.
- IN_VALID toggled 1,0,0,1: no PISO_LOAD while low; strobe spacing preserved. With POOL_SCHED_STALL_CNT_EN defined, STALL_CNT increments by 2.
- RESET asserted during SHIFT: all outputs 0 immediately. A fresh START after release runs the first scenario identically.
